// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg
// Pipeline register between the decode (ID) and execute (EX) stages.
//
// On each rising clock edge the register does exactly one of three things:
//   FLUSH  (flush=1)                        -> insert a bubble (STALL is ignored)
//   HOLD   (flush=0, stall=1)               -> keep all outputs unchanged
//   LOAD   (flush=0, stall=0, id_valid=1)   -> capture the decode stage contents
// When nothing is stalled but decode holds no instruction, a bubble is also
// inserted. Every bubble is counted in a saturating 16-bit counter.
//
// Ports
//   clock               rising-edge clock
//   reset_n             asynchronous active-low reset; clears every output
//   stall               hold all registered outputs
//   flush               replace the next stage contents with a bubble
//   id_valid            decode stage holds a real instruction
//   id_ctrl[7:0]        [7:6] alu_op, [5] alu_src, [4] mem_read,
//                       [3] mem_write, [2] reg_write, [1] mem_to_reg, [0] branch
//   id_instruction      fetched instruction word
//   id_pc               instruction address
//   id_read_data1/2     register file read ports (Rn, Rm/Rt)
//   id_sign_ext         sign-extended immediate
//   ex_valid            execute stage holds a real instruction
//   ex_alu_op           registered id_ctrl[7:6]
//   ex_ctrl             registered id_ctrl[5:0]
//   ex_alu_instruction  registered id_instruction[31:21] (opcode for ALU control)
//   ex_rm/ex_rn/ex_rd   registered register specifiers
//   ex_pc, ex_read_data1, ex_read_data2, ex_sign_ext  registered 64-bit data
//   ex_bubble_cnt       number of bubbles captured since reset (saturating)
// ---------------------------------------------------------------------------
module id_ex_reg (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [7:0]  id_ctrl,
    input  logic [31:0] id_instruction,
    input  logic [63:0] id_pc,
    input  logic [63:0] id_read_data1,
    input  logic [63:0] id_read_data2,
    input  logic [63:0] id_sign_ext,
    output logic        ex_valid,
    output logic [1:0]  ex_alu_op,
    output logic [5:0]  ex_ctrl,
    output logic [10:0] ex_alu_instruction,
    output logic [4:0]  ex_rm,
    output logic [4:0]  ex_rn,
    output logic [4:0]  ex_rd,
    output logic [63:0] ex_pc,
    output logic [63:0] ex_read_data1,
    output logic [63:0] ex_read_data2,
    output logic [63:0] ex_sign_ext,
    output logic [15:0] ex_bubble_cnt
);

    logic bubble;
    logic load;

    // Flush wins over stall; an un-stalled cycle with no valid instruction
    // in decode also becomes a bubble.
    assign bubble = flush | (~stall & ~id_valid);
    assign load   = ~flush & ~stall & id_valid;

    // A bubble zeroes everything, so ex_alu_op=00 selects ADD downstream and
    // ex_ctrl=0 guarantees that ADD has no architectural side effect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid           <= 1'b0;
            ex_alu_op          <= 2'b00;
            ex_ctrl            <= 6'h00;
            ex_alu_instruction <= 11'h000;
            ex_rm              <= 5'h00;
            ex_rn              <= 5'h00;
            ex_rd              <= 5'h00;
            ex_pc              <= 64'h0;
            ex_read_data1      <= 64'h0;
            ex_read_data2      <= 64'h0;
            ex_sign_ext        <= 64'h0;
            ex_bubble_cnt      <= 16'h0000;
        end else if (bubble) begin
            ex_valid           <= 1'b0;
            ex_alu_op          <= 2'b00;
            ex_ctrl            <= 6'h00;
            ex_alu_instruction <= 11'h000;
            ex_rm              <= 5'h00;
            ex_rn              <= 5'h00;
            ex_rd              <= 5'h00;
            ex_pc              <= 64'h0;
            ex_read_data1      <= 64'h0;
            ex_read_data2      <= 64'h0;
            ex_sign_ext        <= 64'h0;
            // Saturate rather than wrap so a long flush storm stays visible.
            if (ex_bubble_cnt != 16'hFFFF) begin
                ex_bubble_cnt <= ex_bubble_cnt + 16'd1;
            end
        end else if (load) begin
            ex_valid           <= 1'b1;
            ex_alu_op          <= id_ctrl[7:6];
            ex_ctrl            <= id_ctrl[5:0];
            ex_alu_instruction <= id_instruction[31:21];
            ex_rm              <= id_instruction[20:16];
            ex_rn              <= id_instruction[9:5];
            ex_rd              <= id_instruction[4:0];
            ex_pc              <= id_pc;
            ex_read_data1      <= id_read_data1;
            ex_read_data2      <= id_read_data2;
            ex_sign_ext        <= id_sign_ext;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_reg
// Directed self-checking bench for id_ex_reg. Expected values are written
// out by hand next to each step.
// ---------------------------------------------------------------------------
module tb_id_ex_reg;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [7:0]  id_ctrl;
    logic [31:0] id_instruction;
    logic [63:0] id_pc;
    logic [63:0] id_read_data1;
    logic [63:0] id_read_data2;
    logic [63:0] id_sign_ext;
    logic        ex_valid;
    logic [1:0]  ex_alu_op;
    logic [5:0]  ex_ctrl;
    logic [10:0] ex_alu_instruction;
    logic [4:0]  ex_rm;
    logic [4:0]  ex_rn;
    logic [4:0]  ex_rd;
    logic [63:0] ex_pc;
    logic [63:0] ex_read_data1;
    logic [63:0] ex_read_data2;
    logic [63:0] ex_sign_ext;
    logic [15:0] ex_bubble_cnt;

    int checks;
    int errors;

    id_ex_reg dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .stall              (stall),
        .flush              (flush),
        .id_valid           (id_valid),
        .id_ctrl            (id_ctrl),
        .id_instruction     (id_instruction),
        .id_pc              (id_pc),
        .id_read_data1      (id_read_data1),
        .id_read_data2      (id_read_data2),
        .id_sign_ext        (id_sign_ext),
        .ex_valid           (ex_valid),
        .ex_alu_op          (ex_alu_op),
        .ex_ctrl            (ex_ctrl),
        .ex_alu_instruction (ex_alu_instruction),
        .ex_rm              (ex_rm),
        .ex_rn              (ex_rn),
        .ex_rd              (ex_rd),
        .ex_pc              (ex_pc),
        .ex_read_data1      (ex_read_data1),
        .ex_read_data2      (ex_read_data2),
        .ex_sign_ext        (ex_sign_ext),
        .ex_bubble_cnt      (ex_bubble_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one full set of decode-stage inputs.
    task automatic applyStimulus(input logic s, input logic f, input logic v,
                                 input logic [7:0] c, input logic [31:0] ins,
                                 input logic [63:0] pc, input logic [63:0] r1,
                                 input logic [63:0] r2, input logic [63:0] se);
        stall          = s;
        flush          = f;
        id_valid       = v;
        id_ctrl        = c;
        id_instruction = ins;
        id_pc          = pc;
        id_read_data1  = r1;
        id_read_data2  = r2;
        id_sign_ext    = se;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Checks that every output is zero (reset or bubble with zero count).
    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"},  {63'b0, ex_valid},           64'h0);
        checkOutput({tag, "_aluop"},  {62'b0, ex_alu_op},          64'h0);
        checkOutput({tag, "_ctrl"},   {58'b0, ex_ctrl},            64'h0);
        checkOutput({tag, "_alui"},   {53'b0, ex_alu_instruction}, 64'h0);
        checkOutput({tag, "_rm"},     {59'b0, ex_rm},              64'h0);
        checkOutput({tag, "_rn"},     {59'b0, ex_rn},              64'h0);
        checkOutput({tag, "_rd"},     {59'b0, ex_rd},              64'h0);
        checkOutput({tag, "_pc"},     ex_pc,                       64'h0);
        checkOutput({tag, "_rd1"},    ex_read_data1,               64'h0);
        checkOutput({tag, "_rd2"},    ex_read_data2,               64'h0);
        checkOutput({tag, "_sx"},     ex_sign_ext,                 64'h0);
        checkOutput({tag, "_cnt"},    {48'b0, ex_bubble_cnt},      64'h0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 64'h0, 64'h0, 64'h0, 64'h0);

        // Reset state; stall stays high across release so nothing counts.
        tick();
        tick();
        checkAllZero("reset");
        #2 reset_n = 1'b1;
        tick();
        checkOutput("post_reset_cnt", {48'b0, ex_bubble_cnt}, 64'h0);

        // LOAD: ADD X0,X1,X2 with ctrl A4.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA4, 32'h8B020020, 64'h100,
                      64'h1111, 64'h2222, 64'h20);
        tick();
        checkOutput("load_valid", {63'b0, ex_valid},           64'h1);
        checkOutput("load_aluop", {62'b0, ex_alu_op},          64'h2);
        checkOutput("load_ctrl",  {58'b0, ex_ctrl},            64'h24);
        checkOutput("load_alui",  {53'b0, ex_alu_instruction}, 64'h458);
        checkOutput("load_rm",    {59'b0, ex_rm},              64'h2);
        checkOutput("load_rn",    {59'b0, ex_rn},              64'h1);
        checkOutput("load_rd",    {59'b0, ex_rd},              64'h0);
        checkOutput("load_pc",    ex_pc,                       64'h100);
        checkOutput("load_rd1",   ex_read_data1,               64'h1111);
        checkOutput("load_rd2",   ex_read_data2,               64'h2222);
        checkOutput("load_sx",    ex_sign_ext,                 64'h20);
        checkOutput("load_cnt",   {48'b0, ex_bubble_cnt},      64'h0);

        // HOLD for 3 cycles with new decode data (invalid in the middle).
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 32'hFFFFFFFF, 64'h104,
                      64'h5555, 64'h6666, 64'h7777);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) id_valid = 1'b0;
            tick();
            checkOutput($sformatf("hold_pc_%0d", i),    ex_pc,                  64'h100);
            checkOutput($sformatf("hold_valid_%0d", i), {63'b0, ex_valid},      64'h1);
            checkOutput($sformatf("hold_ctrl_%0d", i),  {58'b0, ex_ctrl},       64'h24);
            checkOutput($sformatf("hold_cnt_%0d", i),   {48'b0, ex_bubble_cnt}, 64'h0);
        end

        // Release: first load after hold takes the current inputs.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h5B, 32'hF84003E1, 64'h104,
                      64'h5555, 64'h6666, 64'h7777);
        tick();
        checkOutput("release_pc",   ex_pc,               64'h104);
        checkOutput("release_ctrl", {58'b0, ex_ctrl},    64'h1B);
        checkOutput("release_aluop",{62'b0, ex_alu_op},  64'h1);
        checkOutput("release_rn",   {59'b0, ex_rn},      64'h1F);
        checkOutput("release_rd",   {59'b0, ex_rd},      64'h1);
        checkOutput("release_rd1",  ex_read_data1,       64'h5555);

        // Back-to-back loads, one per cycle.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h81, 32'hB4000043, 64'h108,
                      64'hA, 64'hB, 64'h2);
        tick();
        checkOutput("b2b0_pc",  ex_pc,                64'h108);
        checkOutput("b2b0_rd",  {59'b0, ex_rd},       64'h3);
        checkOutput("b2b0_alui",{53'b0, ex_alu_instruction}, 64'h5A0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h64, 32'hCB1F03E9, 64'h10C,
                      64'hC, 64'hD, 64'hFFFFFFFFFFFFFFFF);
        tick();
        checkOutput("b2b1_pc",  ex_pc,                64'h10C);
        checkOutput("b2b1_rm",  {59'b0, ex_rm},       64'h1F);
        checkOutput("b2b1_rd",  {59'b0, ex_rd},       64'h9);
        checkOutput("b2b1_sx",  ex_sign_ext,          64'hFFFFFFFFFFFFFFFF);
        checkOutput("b2b1_valid", {63'b0, ex_valid},  64'h1);

        // FLUSH with STALL and a valid instruction: bubble, count to 1.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 32'h8B020020, 64'h200,
                      64'h1, 64'h2, 64'h3);
        tick();
        checkOutput("fs_valid", {63'b0, ex_valid},      64'h0);
        checkOutput("fs_ctrl",  {58'b0, ex_ctrl},       64'h0);
        checkOutput("fs_aluop", {62'b0, ex_alu_op},     64'h0);
        checkOutput("fs_pc",    ex_pc,                  64'h0);
        checkOutput("fs_cnt",   {48'b0, ex_bubble_cnt}, 64'h1);

        // Invalid input without stall: bubble, count to 2.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF, 32'hFFFFFFFF, 64'h204,
                      64'h1, 64'h2, 64'h3);
        tick();
        checkOutput("inv_valid", {63'b0, ex_valid},      64'h0);
        checkOutput("inv_ctrl",  {58'b0, ex_ctrl},       64'h0);
        checkOutput("inv_rd2",   ex_read_data2,          64'h0);
        checkOutput("inv_cnt",   {48'b0, ex_bubble_cnt}, 64'h2);

        // Load something nonzero, then assert reset mid-stall between edges.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 32'hFFFFFFFF, 64'h208,
                      64'h9, 64'h8, 64'h7);
        tick();
        checkOutput("preRst_valid", {63'b0, ex_valid},      64'h1);
        checkOutput("preRst_cnt",   {48'b0, ex_bubble_cnt}, 64'h2);
        stall = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checkAllZero("asyncRst");
        #2 reset_n = 1'b1;

        // Saturation: consecutive bubbles from a cleared counter.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        for (int i = 0; i < 65534; i++) begin
            tick();
        end
        checkOutput("sat_fffe", {48'b0, ex_bubble_cnt}, 64'hFFFE);
        flush = 1'b1;
        tick();
        checkOutput("sat_ffff", {48'b0, ex_bubble_cnt}, 64'hFFFF);
        tick();
        checkOutput("sat_hold1", {48'b0, ex_bubble_cnt}, 64'hFFFF);
        flush = 1'b0;
        tick();
        checkOutput("sat_hold2", {48'b0, ex_bubble_cnt}, 64'hFFFF);
        checkOutput("sat_valid", {63'b0, ex_valid},      64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have CLOCK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have RESET_N  input  1  asynchronous, active-low reset.
REQ-003 SHALL have STALL  input  1  hold all registered outputs unchanged.
REQ-004 SHALL have FLUSH  input  1  replace next stage contents with a bubble.
REQ-005 SHALL have ID_VALID  input  1  decode stage holds a real instruction.
REQ-006 SHALL have ID_CTRL  input  8  decode controls: [7:6] ALU_Op, [5] ALU_SRC, [4] MEM_READ, [3] MEM_WRITE, [2] REG_WRITE, [1] MEM_TO_REG, [0] BRANCH.
REQ-007 SHALL have ID_INSTRUCTION  input  32  fetched instruction word.
REQ-008 SHALL have ID_PC  input  64  instruction address.
REQ-009 SHALL have ID_READ_DATA1  input  64  register file port 1 (Rn).
REQ-010 SHALL have ID_READ_DATA2  input  64  register file port 2 (Rm/Rt).
REQ-011 SHALL have ID_SIGN_EXT  input  64  sign-extended immediate.
REQ-012 SHALL have EX_VALID  output  1  execute stage holds a real instruction.
REQ-013 SHALL have EX_ALU_Op  output  2  registered ID_CTRL[7:6], drives ALU control.
REQ-014 SHALL have EX_CTRL  output  6  registered ID_CTRL[5:0], same bit order.
REQ-015 SHALL have EX_ALU_INSTRUCTION  output  11  registered ID_INSTRUCTION[31:21], drives ALU control.
REQ-016 SHALL have EX_RM  output  5  registered ID_INSTRUCTION[20:16].
REQ-017 SHALL have EX_RN  output  5  registered ID_INSTRUCTION[9:5].
REQ-018 SHALL have EX_RD  output  5  registered ID_INSTRUCTION[4:0].
REQ-019 SHALL have EX_PC, EX_READ_DATA1, EX_READ_DATA2, EX_SIGN_EXT  output  64 each  registered copies of the ID_ inputs.
REQ-020 SHALL have EX_BUBBLE_CNT  output  16  count of bubbles captured since reset.

Function
REQ-021 SHALL update on each rising CLOCK edge with priority FLUSH > STALL > LOAD; outputs purely registered, no combinational input-to-output path.
REQ-022 LOAD (FLUSH=0, STALL=0, ID_VALID=1) SHALL capture all ID_ fields and set EX_VALID=1; latency exactly one cycle.
REQ-023 BUBBLE (FLUSH=1, or FLUSH=0 and STALL=0 and ID_VALID=0) SHALL clear EX_VALID, EX_ALU_Op, EX_CTRL, EX_ALU_INSTRUCTION, EX_RM, EX_RN, EX_RD, and all 64-bit outputs to 0.
REQ-024 HOLD (FLUSH=0, STALL=1) SHALL keep every output, including EX_BUBBLE_CNT, unchanged regardless of ID_VALID and ID_ data.
REQ-025 FLUSH=1 with STALL=1 in the same cycle SHALL produce a BUBBLE; the stall is ignored.
REQ-026 Each BUBBLE cycle SHALL increment EX_BUBBLE_CNT by 1; it saturates at 16'hFFFF and does not wrap.
REQ-027 A bubble's zeroed EX_ALU_Op (2'b00) SHALL make the downstream ALU control select ADD, which has no architectural side effect because EX_CTRL is 0.
REQ-028 Back-to-back LOAD cycles SHALL sustain one instruction per cycle with no idle cycle inserted.
REQ-029 Repeated HOLD cycles SHALL be unlimited in length; the first LOAD after a hold SHALL capture the then-current ID_ inputs.

Reset
REQ-030 RESET_N=0 SHALL asynchronously force every output to 0 (EX_VALID=0, EX_BUBBLE_CNT=0) independent of CLOCK.
REQ-031 Deassertion of RESET_N SHALL take effect at the next rising edge; an assertion mid-stall or mid-flush SHALL override both immediately.

Verification
REQ-032 Reset: drive RESET_N=0 between clock edges with outputs nonzero -> all outputs read 0 before the next edge.
REQ-033 LOAD: ID_VALID=1, ID_CTRL=8'hA4, ID_INSTRUCTION=32'h8B020020 (ADD X0,X1,X2) -> next cycle EX_VALID=1, EX_ALU_Op=2'b10, EX_CTRL=6'h24, EX_ALU_INSTRUCTION=11'b10001011000, EX_RM=2, EX_RN=1, EX_RD=0.
REQ-034 STALL: load ID_PC=64'h100, then hold STALL=1 for 3 cycles while ID_PC=64'h104 -> EX_PC remains 64'h100 and EX_BUBBLE_CNT is unchanged; on release EX_PC=64'h104.
REQ-035 FLUSH+STALL: both asserted with a valid instruction present -> next cycle EX_VALID=0, EX_CTRL=0, EX_BUBBLE_CNT incremented by 1.
REQ-036 Saturation: 65537 consecutive bubbles -> EX_BUBBLE_CNT=16'hFFFF and stays there.
REQ-037 Invalid input: ID_VALID=0, STALL=0, ID_CTRL=8'hFF -> next cycle EX_VALID=0 and EX_CTRL=0.
